spi_flash_boot_reader: RTL and testbench

- Hardware SPI initiator that fetches a program image from an external serial flash and streams it into instruction memory as 32-bit words.
- It is the master end of the flash-read protocol: it drives CS, SCK and MOSI, and captures the data the flash returns on MISO.
- Sits between the SoC pad-level SPI pins and the instruction-memory write port; the boot path uses it instead of bit-banging SPI in software.

---
 rtl/spi_flash_pkg.sv | 27 ++
 rtl/spi_flash_boot_reader_sck_gen.sv | 43 ++++
 rtl/spi_flash_boot_reader.sv | 164 ++++++++++++++++
 tb/tb_spi_flash_boot_reader.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash boot reader.
//   state_t    : FSM states of the reader
//   READ_CMD   : serial-flash "read data" opcode sent before the address
//   HDR_BITS   : command + address bits shifted out per transfer
//   WORD_BITS  : data bits received per instruction word
//   le_word()  : reorders four MSB-first received bytes into a little-endian word
package spi_flash_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        WRITE,
        FINISH
    } state_t;

    localparam logic [7:0] READ_CMD  = 8'h03;
    localparam int         HDR_BITS  = 32;
    localparam int         WORD_BITS = 32;

    // raw holds the bytes in arrival order, first byte in [31:24].
    function automatic logic [31:0] le_word(input logic [31:0] raw);
        return {raw[7:0], raw[15:8], raw[23:16], raw[31:24]};
    endfunction

endpackage

// File: rtl/spi_flash_boot_reader_sck_gen.sv
// SCK generator for the SPI flash boot reader (mode 0, idles low).
//   clk, rst  : system clock, synchronous active-high reset
//   en        : run the divider; when low, SCK is forced low and the divider cleared
//   pause     : freeze divider and SCK in their current state
//   sck       : registered serial clock
//   rise_stb  : high in the cycle whose clock edge drives SCK 0->1
//   fall_stb  : high in the cycle whose clock edge drives SCK 1->0
module spi_sck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic pause,
    output logic sck,
    output logic rise_stb,
    output logic fall_stb
);

    localparam logic [7:0] DIV_TC = 8'(CLK_DIV - 1);

    logic [7:0] div_cnt;
    logic       tc;

    assign tc       = en && !pause && (div_cnt == DIV_TC);
    assign rise_stb = tc && !sck;
    assign fall_stb = tc && sck;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            div_cnt <= '0;
            sck     <= 1'b0;
        end else if (!pause) begin
            if (div_cnt == DIV_TC) begin
                div_cnt <= '0;
                sck     <= ~sck;
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/spi_flash_boot_reader.sv
// SPI flash boot reader: issues a 0x03 read to a serial flash and streams the
// returned image into instruction memory as little-endian 32-bit words.
//   clock, reset      : system clock, synchronous active-high reset
//   io_start          : start request, honoured only while idle
//   io_base_addr      : flash byte address of the first word (latched at start)
//   io_num_words      : number of words to fetch (latched at start)
//   io_busy, io_done  : transfer in progress / one-cycle completion pulse
//   io_spi_cs/clk/mosi: flash chip select (active low), SCK (mode 0), MOSI
//   io_spi_miso       : flash data in
//   io_wr_en/addr/data: instruction-memory write, accepted when io_wr_ready
module spi_flash_boot_reader
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int WADDR_W = 9,
    parameter int CNT_W   = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               io_start,
    input  logic [23:0]        io_base_addr,
    input  logic [CNT_W-1:0]   io_num_words,
    output logic               io_busy,
    output logic               io_done,
    output logic               io_spi_cs,
    output logic               io_spi_clk,
    output logic               io_spi_mosi,
    input  logic               io_spi_miso,
    output logic               io_wr_en,
    output logic [WADDR_W-1:0] io_wr_addr,
    output logic [31:0]        io_wr_data,
    input  logic               io_wr_ready
);

    state_t           state;
    logic [31:0]      tx_sh;
    logic [31:0]      rx_sh;
    logic [5:0]       bit_cnt;
    logic [CNT_W-1:0] words_left;

    logic sck_en;
    logic sck_pause;
    logic rise_stb;
    logic fall_stb;

    // SCK runs for the whole CS-low window; WRITE freezes it low so a stalled
    // memory simply stretches the gap before the next word.
    assign sck_en    = (state == CMD) || (state == ADDR) || (state == DATA) || (state == WRITE);
    assign sck_pause = (state == WRITE);

    spi_sck_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sck_gen (
        .clk      (clock),
        .rst      (reset),
        .en       (sck_en),
        .pause    (sck_pause),
        .sck      (io_spi_clk),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    // Shift registers carry data only and need no reset.
    always_ff @(posedge clock) begin
        if (state == IDLE && io_start) begin
            tx_sh <= {READ_CMD, io_base_addr};
        end else if ((state == CMD || state == ADDR) && fall_stb) begin
            tx_sh <= tx_sh << 1;
        end
        if (state == DATA && rise_stb) begin
            rx_sh <= {rx_sh[30:0], io_spi_miso};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            io_spi_cs   <= 1'b1;
            io_spi_mosi <= 1'b0;
            io_busy     <= 1'b0;
            io_done     <= 1'b0;
            io_wr_en    <= 1'b0;
            io_wr_addr  <= '0;
            io_wr_data  <= '0;
            bit_cnt     <= '0;
            words_left  <= '0;
        end else begin
            io_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (io_start) begin
                        io_wr_addr <= '0;
                        words_left <= io_num_words;
                        bit_cnt    <= '0;
                        if (io_num_words == '0) begin
                            // Nothing to fetch: complete without touching the bus.
                            state   <= FINISH;
                            io_done <= 1'b1;
                        end else begin
                            state       <= CMD;
                            io_spi_cs   <= 1'b0;
                            io_busy     <= 1'b1;
                            io_spi_mosi <= READ_CMD[7];
                        end
                    end
                end

                CMD, ADDR: begin
                    // Header bits advance on SCK falls; bit_cnt counts falls seen.
                    if (fall_stb) begin
                        io_spi_mosi <= tx_sh[30];
                        bit_cnt     <= bit_cnt + 6'd1;
                        if (bit_cnt == 6'(HDR_BITS - 1)) begin
                            state       <= DATA;
                            bit_cnt     <= '0;
                            io_spi_mosi <= 1'b0;
                        end else if (bit_cnt == 6'd7) begin
                            state <= ADDR;
                        end
                    end
                end

                DATA: begin
                    // bit_cnt counts rises; the word closes on the fall after the last one.
                    if (rise_stb) begin
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                    if (fall_stb && bit_cnt == 6'(WORD_BITS)) begin
                        state      <= WRITE;
                        bit_cnt    <= '0;
                        io_wr_en   <= 1'b1;
                        io_wr_data <= le_word(rx_sh);
                    end
                end

                WRITE: begin
                    if (io_wr_ready) begin
                        io_wr_en   <= 1'b0;
                        io_wr_addr <= io_wr_addr + WADDR_W'(1);
                        words_left <= words_left - CNT_W'(1);
                        if (words_left == CNT_W'(1)) begin
                            state     <= FINISH;
                            io_spi_cs <= 1'b1;
                            io_done   <= 1'b1;
                            io_busy   <= 1'b0;
                        end else begin
                            // Continuous read: the flash keeps streaming, no new header.
                            state <= DATA;
                        end
                    end
                end

                FINISH: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_boot_reader.sv
module tb_spi_flash_boot_reader;

    localparam int CLK_DIV = 4;
    localparam int WADDR_W = 9;
    localparam int CNT_W   = 10;
    localparam int CLK_P   = 10;

    logic               clk = 1'b0;
    logic               reset;
    logic               io_start;
    logic [23:0]        io_base_addr;
    logic [CNT_W-1:0]   io_num_words;
    logic               io_busy;
    logic               io_done;
    logic               io_spi_cs;
    logic               io_spi_clk;
    logic               io_spi_mosi;
    logic               io_spi_miso;
    logic               io_wr_en;
    logic [WADDR_W-1:0] io_wr_addr;
    logic [31:0]        io_wr_data;
    logic               io_wr_ready;

    always #(CLK_P / 2) clk = ~clk;

    spi_flash_boot_reader #(
        .CLK_DIV(CLK_DIV),
        .WADDR_W(WADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clock        (clk),
        .reset        (reset),
        .io_start     (io_start),
        .io_base_addr (io_base_addr),
        .io_num_words (io_num_words),
        .io_busy      (io_busy),
        .io_done      (io_done),
        .io_spi_cs    (io_spi_cs),
        .io_spi_clk   (io_spi_clk),
        .io_spi_mosi  (io_spi_mosi),
        .io_spi_miso  (io_spi_miso),
        .io_wr_en     (io_wr_en),
        .io_wr_addr   (io_wr_addr),
        .io_wr_data   (io_wr_data),
        .io_wr_ready  (io_wr_ready)
    );

    int nchk = 0;
    int nerr = 0;

    // Flash model: captures the header on SCK rises, shifts data out on SCK falls.
    logic [7:0]  fb [8];
    logic [31:0] mosi_cap;
    int          rise_cnt;
    int          fall_cnt;
    int          sck_period;
    time         last_rise;
    bit          have_rise;

    initial begin
        rise_cnt    = 0;
        fall_cnt    = 0;
        mosi_cap    = '0;
        io_spi_miso = 1'b0;
        sck_period  = 0;
        have_rise   = 1'b0;
        last_rise   = 0;
    end

    always @(negedge io_spi_cs) begin
        rise_cnt    = 0;
        fall_cnt    = 0;
        mosi_cap    = '0;
        have_rise   = 1'b0;
        io_spi_miso = 1'b0;
    end

    always @(posedge io_spi_clk) begin
        if (io_spi_cs === 1'b0) begin
            if (rise_cnt < 32) mosi_cap = {mosi_cap[30:0], io_spi_mosi};
            rise_cnt = rise_cnt + 1;
            if (have_rise) sck_period = int'(($time - last_rise) / CLK_P);
            last_rise = $time;
            have_rise = 1'b1;
        end
    end

    always @(negedge io_spi_clk) begin
        if (io_spi_cs === 1'b0) begin
            int d;
            fall_cnt = fall_cnt + 1;
            if (fall_cnt >= 32) begin
                d = fall_cnt - 32;
                io_spi_miso = fb[(d / 8) % 8][7 - (d % 8)];
            end
        end
    end

    // Write / done / CS monitor, sampled on the inactive edge.
    logic [31:0] wr_data_log [16];
    logic [31:0] wr_addr_log [16];
    int          n_wr;
    int          done_cnt;
    int          cs_low;
    int          sck_rises;

    initial begin
        n_wr      = 0;
        done_cnt  = 0;
        cs_low    = 0;
        sck_rises = 0;
    end

    always @(posedge io_spi_clk) sck_rises = sck_rises + 1;

    always @(negedge clk) begin
        if (io_wr_en === 1'b1 && io_wr_ready === 1'b1) begin
            if (n_wr < 16) begin
                wr_data_log[n_wr] = io_wr_data;
                wr_addr_log[n_wr] = 32'(io_wr_addr);
            end
            n_wr = n_wr + 1;
        end
        if (io_done === 1'b1) done_cnt = done_cnt + 1;
        if (io_spi_cs === 1'b0) cs_low = cs_low + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk = nchk + 1;
        assert (obs === exp) else begin
            nerr = nerr + 1;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        n_wr     = 0;
        done_cnt = 0;
        cs_low   = 0;
    endtask

    // kind: 0 = io_done, 1 = io_wr_en, 2 = rise_cnt >= arg, 3 = fall_cnt >= arg
    task automatic wait_for(input int kind, input int arg, input int budget, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if ((kind == 0 && io_done === 1'b1) || (kind == 1 && io_wr_en === 1'b1) ||
                (kind == 2 && rise_cnt >= arg) || (kind == 3 && fall_cnt >= arg)) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic start_xfer(input logic [23:0] base, input logic [CNT_W-1:0] cnt);
        io_base_addr = base;
        io_num_words = cnt;
        io_start     = 1'b1;
        tick();
        io_start     = 1'b0;
    endtask

    initial begin
        int bad;
        int rises_snap;

        reset        = 1'b1;
        io_start     = 1'b0;
        io_base_addr = '0;
        io_num_words = '0;
        io_wr_ready  = 1'b1;
        fb[0] = 8'h13; fb[1] = 8'h00; fb[2] = 8'h00; fb[3] = 8'h00;
        fb[4] = 8'h93; fb[5] = 8'h00; fb[6] = 8'h10; fb[7] = 8'h00;
        repeat (3) tick();

        // Reset values
        chk("rst_cs",      32'(io_spi_cs),   32'd1);
        chk("rst_sck",     32'(io_spi_clk),  32'd0);
        chk("rst_mosi",    32'(io_spi_mosi), 32'd0);
        chk("rst_busy",    32'(io_busy),     32'd0);
        chk("rst_done",    32'(io_done),     32'd0);
        chk("rst_wr_en",   32'(io_wr_en),    32'd0);
        chk("rst_wr_addr", 32'(io_wr_addr),  32'd0);
        chk("rst_wr_data", io_wr_data,       32'd0);
        reset = 1'b0;
        tick();

        // Basic two-word read from address 0
        clear_logs();
        start_xfer(24'h000000, 10'd2);
        chk("t1_busy_after_start", 32'(io_busy),     32'd1);
        chk("t1_cs_low",           32'(io_spi_cs),   32'd0);
        chk("t1_mosi_first",       32'(io_spi_mosi), 32'd0);
        chk("t1_sck_low",          32'(io_spi_clk),  32'd0);
        wait_for(0, 0, 3000, "t1_done_timeout");
        chk("t1_busy_at_done", 32'(io_busy),   32'd0);
        chk("t1_cs_at_done",   32'(io_spi_cs), 32'd1);
        repeat (4) tick();
        chk("t1_header",   mosi_cap,       32'h03000000);
        chk("t1_nwr",      32'(n_wr),      32'd2);
        chk("t1_addr0",    wr_addr_log[0], 32'd0);
        chk("t1_data0",    wr_data_log[0], 32'h00000013);
        chk("t1_addr1",    wr_addr_log[1], 32'd1);
        chk("t1_data1",    wr_data_log[1], 32'h00100093);
        chk("t1_done_cnt", 32'(done_cnt),  32'd1);
        chk("t1_cs_low",   32'(cs_low),    32'd770);

        // Backpressure on word 0
        clear_logs();
        io_wr_ready = 1'b0;
        start_xfer(24'h000010, 10'd2);
        wait_for(1, 0, 2000, "t2_wr_en_timeout");
        chk("t2_addr0", 32'(io_wr_addr), 32'd0);
        chk("t2_data0", io_wr_data,      32'h00000013);
        rises_snap = sck_rises;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (io_wr_en !== 1'b1 || io_wr_addr !== '0 || io_wr_data !== 32'h00000013 ||
                io_spi_clk !== 1'b0 || io_spi_cs !== 1'b0) bad = bad + 1;
        end
        chk("t2_stall_stable", 32'(bad),       32'd0);
        chk("t2_no_sck_edges", 32'(sck_rises), 32'(rises_snap));
        chk("t2_no_accept",    32'(n_wr),      32'd0);
        io_wr_ready = 1'b1;
        wait_for(0, 0, 2000, "t2_done_timeout");
        repeat (2) tick();
        chk("t2_header", mosi_cap,       32'h03000010);
        chk("t2_nwr",    32'(n_wr),      32'd2);
        chk("t2_data0",  wr_data_log[0], 32'h00000013);
        chk("t2_addr1",  wr_addr_log[1], 32'd1);
        chk("t2_data1",  wr_data_log[1], 32'h00100093);
        chk("t2_cs_low", 32'(cs_low),    32'd790);

        // Zero word count
        clear_logs();
        start_xfer(24'h000200, 10'd0);
        chk("t3_done_pulse", 32'(io_done),   32'd1);
        chk("t3_busy",       32'(io_busy),   32'd0);
        chk("t3_cs",         32'(io_spi_cs), 32'd1);
        tick();
        chk("t3_done_drop",  32'(io_done),   32'd0);
        repeat (10) tick();
        chk("t3_cs_never_low", 32'(cs_low),   32'd0);
        chk("t3_done_cnt",     32'(done_cnt), 32'd1);
        chk("t3_nwr",          32'(n_wr),     32'd0);

        // Reset in the middle of the address phase
        clear_logs();
        start_xfer(24'h123456, 10'd1);
        wait_for(2, 12, 500, "t4_bit12_timeout");
        chk("t4_cs_before", 32'(io_spi_cs), 32'd0);
        reset = 1'b1;
        tick();
        chk("t4_cs",    32'(io_spi_cs),  32'd1);
        chk("t4_sck",   32'(io_spi_clk), 32'd0);
        chk("t4_busy",  32'(io_busy),    32'd0);
        chk("t4_wr_en", 32'(io_wr_en),   32'd0);
        reset = 1'b0;
        repeat (40) tick();
        chk("t4_no_write", 32'(n_wr), 32'd0);
        clear_logs();
        start_xfer(24'h000100, 10'd1);
        wait_for(0, 0, 2000, "t4_done_timeout");
        repeat (2) tick();
        chk("t4_header", mosi_cap,       32'h03000100);
        chk("t4_nwr",    32'(n_wr),      32'd1);
        chk("t4_data0",  wr_data_log[0], 32'h00000013);

        // Start while busy, SCK period and rise-edge sampling
        clear_logs();
        fb[0] = 8'hA5; fb[1] = 8'h3C; fb[2] = 8'h0F; fb[3] = 8'hF0;
        start_xfer(24'h000000, 10'd1);
        wait_for(3, 40, 1000, "t5_data_timeout");
        start_xfer(24'h000400, 10'd5);
        chk("t5_busy_kept", 32'(io_busy), 32'd1);
        wait_for(0, 0, 2000, "t5_done_timeout");
        repeat (20) tick();
        chk("t5_nwr",       32'(n_wr),      32'd1);
        chk("t5_addr0",     wr_addr_log[0], 32'd0);
        chk("t5_data0",     wr_data_log[0], 32'hF00F3CA5);
        chk("t5_done_cnt",  32'(done_cnt),  32'd1);
        chk("t5_sck_period", 32'(sck_period), 32'd8);
        chk("t5_idle_cs",   32'(io_spi_cs), 32'd1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
